// File: rtl/dpf_pkg.sv
// Shared definitions for the dynamic-partition trace generator.
//   dpf_state_t : 8-bit packed system state {m1, m0, b[2:0], a[2:0]} (a in the LSBs)
//   INIT_STATE  : the all-zero initial state; a trace closes when it is reached again
//   dpf_fsm_e   : trace generator FSM encoding
package dpf_pkg;

    typedef struct packed {
        logic       m1;
        logic       m0;
        logic [2:0] b;
        logic [2:0] a;
    } dpf_state_t;

    localparam logic [7:0] INIT_STATE = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } dpf_fsm_e;

endpackage

// File: rtl/dpf_next_state.sv
// Combinational transition function of the dynamic-partition system.
//   cur : current packed state
//   nxt : successor state
// The two mode bits form a 4-cycle ring; their XOR selects which counter
// advances, so A and B each step twice per mode period.
module dpf_next_state
    import dpf_pkg::*;
(
    input  logic [7:0] cur,
    output logic [7:0] nxt
);

    dpf_state_t s;
    dpf_state_t n;
    logic       sel;

    always_comb begin
        s     = dpf_state_t'(cur);
        sel   = s.m0 ^ s.m1;
        n     = s;
        n.a   = sel ? s.a : s.a + 3'd1;
        n.b   = sel ? s.b + 3'd1 : s.b;
        n.m0  = ~s.m1;
        n.m1  = s.m0;
        nxt   = n;
    end

endmodule

// File: rtl/dpf_trace_gen.sv
// Sequential trace generator: walks the transition function from INIT_STATE
// and streams (current, next) pairs over a valid/ready interface.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begins a trace from IDLE or DONE (ignored while emitting)
//   max_steps     : beat limit latched on start, 0 = stop on fixpoint only
//   out_valid/out_ready, out_cur, out_nxt : pair stream
//   step_count    : accepted beats in the current trace
//   busy, done    : FSM in EMIT / in DONE
//   fixpoint_hit  : in DONE, the trace closed by returning to INIT_STATE
module dpf_trace_gen
    import dpf_pkg::*;
#(
    parameter int         CNT_W      = 8,
    parameter logic [7:0] INIT_STATE = dpf_pkg::INIT_STATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] max_steps,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_cur,
    output logic [7:0]       out_nxt,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
    output logic             done,
    output logic             fixpoint_hit
);

    dpf_fsm_e         state_q, state_d;
    logic [7:0]       cur_q, cur_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             fix_q, fix_d;
    // Last accepted pair, presented on the outputs outside EMIT so DONE
    // holds the final beat rather than the advanced cur register.
    logic [7:0]       last_cur_q, last_cur_d;
    logic [7:0]       last_nxt_q, last_nxt_d;

    logic [7:0]       nxt;
    logic [CNT_W-1:0] step_inc;

    dpf_next_state u_next (
        .cur (cur_q),
        .nxt (nxt)
    );

    assign step_inc = step_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= 8'h00;
            step_q     <= '0;
            max_q      <= '0;
            fix_q      <= 1'b0;
            last_cur_q <= 8'h00;
            last_nxt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            step_q     <= step_d;
            max_q      <= max_d;
            fix_q      <= fix_d;
            last_cur_q <= last_cur_d;
            last_nxt_q <= last_nxt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        step_d     = step_q;
        max_d      = max_q;
        fix_d      = fix_q;
        last_cur_d = last_cur_q;
        last_nxt_d = last_nxt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cur_d   = INIT_STATE;
                    step_d  = '0;
                    max_d   = max_steps;
                    fix_d   = 1'b0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    step_d     = step_inc;
                    cur_d      = nxt;
                    last_cur_d = cur_q;
                    last_nxt_d = nxt;
                    // Fixpoint is tested first so it wins over a limit
                    // reached on the same beat.
                    if (nxt == INIT_STATE) begin
                        fix_d   = 1'b1;
                        state_d = DONE;
                    end else if (max_q != '0 && step_inc == max_q) begin
                        fix_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid    = (state_q == EMIT);
        busy         = (state_q == EMIT);
        done         = (state_q == DONE);
        fixpoint_hit = fix_q;
        step_count   = step_q;
        out_cur      = (state_q == EMIT) ? cur_q : last_cur_q;
        out_nxt      = (state_q == EMIT) ? nxt   : last_nxt_q;
    end

endmodule

// File: tb/tb_dpf_trace_gen.sv
module tb_dpf_trace_gen;
    import dpf_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] max_steps;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_cur;
    logic [7:0] out_nxt;
    logic [7:0] step_count;
    logic       busy;
    logic       done;
    logic       fixpoint_hit;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dpf_trace_gen #(.CNT_W(8), .INIT_STATE(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .max_steps    (max_steps),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_cur      (out_cur),
        .out_nxt      (out_nxt),
        .step_count   (step_count),
        .busy         (busy),
        .done         (done),
        .fixpoint_hit (fixpoint_hit)
    );

    // Reference trace: a chain of transition-function instances from INIT_STATE.
    logic [7:0] ref_chain [0:16];
    assign ref_chain[0] = INIT_STATE;
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_ref
            dpf_next_state u_ref (.cur(ref_chain[gi]), .nxt(ref_chain[gi+1]));
        end
    endgenerate

    typedef struct {
        logic [7:0] cur;
        logic [7:0] nxt;
    } pair_t;

    pair_t exp_q[$];

    typedef struct {
        logic [7:0] max;
        int         beats;
        logic       fix;
        logic [7:0] last_nxt;
        logic       bp;
    } row_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: each observed handshake pops one expected pair.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'd1, 32'd0);
            end else begin
                pair_t e;
                e = exp_q.pop_front();
                $display("beat %0d: cur=%02h nxt=%02h (expect %02h,%02h)",
                         step_count + 8'd1, out_cur, out_nxt, e.cur, e.nxt);
                check("beat_cur", {24'd0, out_cur}, {24'd0, e.cur});
                check("beat_nxt", {24'd0, out_nxt}, {24'd0, e.nxt});
            end
        end
    end

    task automatic push_trace(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            pair_t p;
            p.cur = ref_chain[i % 16];
            p.nxt = ref_chain[(i % 16) + 1];
            exp_q.push_back(p);
        end
    endtask

    task automatic push_pair(input logic [7:0] c, input logic [7:0] n);
        pair_t p;
        p.cur = c;
        p.nxt = n;
        exp_q.push_back(p);
    endtask

    // Pulse start for one cycle; returns #1 after the edge that sampled it.
    task automatic do_start(input logic [7:0] lim);
        @(posedge clk);
        #1;
        start     = 1'b1;
        max_steps = lim;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("first_beat_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_done(input logic bp);
        int cyc;
        cyc = 0;
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            if (bp) out_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        out_ready = 1'b1;
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_end(input string tag, input int beats, input logic fix, input logic [7:0] lnxt);
        $display("trace %s end: step_count=%0d fixpoint_hit=%0d out_nxt=%02h", tag, step_count, fixpoint_hit, out_nxt);
        check({tag, "_steps"}, {24'd0, step_count}, beats);
        check({tag, "_fix"}, {31'd0, fixpoint_hit}, {31'd0, fix});
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_last_nxt"}, {24'd0, out_nxt}, {24'd0, lnxt});
        check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    row_t rows [7];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rows[0] = '{max: 8'd0,   beats: 16, fix: 1'b1, last_nxt: 8'h00, bp: 1'b0};
        rows[1] = '{max: 8'd5,   beats: 5,  fix: 1'b0, last_nxt: 8'h53, bp: 1'b0};
        rows[2] = '{max: 8'd16,  beats: 16, fix: 1'b1, last_nxt: 8'h00, bp: 1'b0};
        rows[3] = '{max: 8'd1,   beats: 1,  fix: 1'b0, last_nxt: 8'h41, bp: 1'b0};
        rows[4] = '{max: 8'd15,  beats: 15, fix: 1'b0, last_nxt: 8'hB8, bp: 1'b1};
        rows[5] = '{max: 8'd17,  beats: 16, fix: 1'b1, last_nxt: 8'h00, bp: 1'b1};
        rows[6] = '{max: 8'd255, beats: 16, fix: 1'b1, last_nxt: 8'h00, bp: 1'b0};

        rst = 1'b1; start = 1'b0; max_steps = 8'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_fix",   {31'd0, fixpoint_hit}, 32'd0);
        check("rst_cur",   {24'd0, out_cur}, 32'd0);
        check("rst_nxt",   {24'd0, out_nxt}, 32'd0);
        check("rst_steps", {24'd0, step_count}, 32'd0);
        rst = 1'b0;

        // Free run with hand-derived first five beats.
        push_pair(8'h00, 8'h41);
        push_pair(8'h41, 8'hC9);
        push_pair(8'hC9, 8'h8A);
        push_pair(8'h8A, 8'h12);
        push_pair(8'h12, 8'h53);
        push_trace(5, 11);
        do_start(8'd0);
        wait_done(1'b0);
        check_end("free", 16, 1'b1, 8'h00);
        check("free_done", {31'd0, done}, 32'd1);

        // Table of limit / backpressure scenarios, each restarted from DONE.
        foreach (rows[r]) begin
            push_trace(0, rows[r].beats);
            do_start(rows[r].max);
            wait_done(rows[r].bp);
            check_end($sformatf("row%0d", r), rows[r].beats, rows[r].fix, rows[r].last_nxt);
        end

        // Backpressure while beat 2 is presented.
        push_trace(0, 16);
        do_start(8'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_cur", {24'd0, out_cur}, 32'h41);
            check("bp_nxt", {24'd0, out_nxt}, 32'hC9);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(1'b0);
        check_end("bp", 16, 1'b1, 8'h00);

        // start during EMIT after beat 3 is ignored.
        push_trace(0, 16);
        do_start(8'd0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        check("emit_start_cur", {24'd0, out_cur}, 32'h8A);
        check("emit_start_nxt", {24'd0, out_nxt}, 32'h12);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0);
        check_end("emit_start", 16, 1'b1, 8'h00);

        // Reset after beat 7, then restart.
        push_trace(0, 16);
        do_start(8'd0);
        begin
            int cyc;
            cyc = 0;
            while (step_count != 8'd7 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            check("mid_rst_reach7", {24'd0, step_count}, 32'd7);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        check("mid_rst_done",  {31'd0, done}, 32'd0);
        check("mid_rst_steps", {24'd0, step_count}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        push_trace(0, 2);
        do_start(8'd2);
        check("restart_cur", {24'd0, out_cur}, 32'h00);
        check("restart_nxt", {24'd0, out_nxt}, 32'h41);
        wait_done(1'b0);
        check_end("restart", 2, 1'b0, 8'hC9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dpf_trace_gen.md
Name: dpf_trace_gen

Overview:
- Sequential trace generator for the small dynamic-partition transition system.
- Starts from the all-zero initial state and steps the transition function one beat at a time.
- Each beat emits a (current, next) state pair over a valid/ready stream to the downstream combinational fixpoint checker.
- Stops when the trace returns to the initial state (fixpoint/cycle closed) or when a programmable step limit is reached.

Parameters:
- CNT_W, 8, width of the step counter and of max_steps.
- INIT_STATE, 8'h00, initial state loaded on start; fixpoint is declared when nxt equals this value.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins a trace when the FSM is IDLE or DONE.
- max_steps  input  CNT_W  beat limit, sampled on start; 0 = run until fixpoint only.
- out_valid  output  1  a pair is presented.
- out_ready  input  1  downstream accepts the pair.
- out_cur  output  8  current state.
- out_nxt  output  8  successor of out_cur.
- step_count  output  CNT_W  number of accepted beats in this trace.
- busy  output  1  FSM is in EMIT.
- done  output  1  FSM is in DONE; held until the next start or rst.
- fixpoint_hit  output  1  valid in DONE: the last accepted out_nxt equalled INIT_STATE.

Behaviour:
- State packing, LSB first:
  - [2:0] = counter A.
  - [5:3] = counter B.
  - [6] = m0.
  - [7] = m1.
- Transition function:
  - sel = m0 ^ m1.
  - A' = sel ? A : A+1 (mod 8).
  - B' = sel ? B+1 (mod 8) : B.
  - m0' = ~m1.
  - m1' = m0.
  - The mode bits cycle with period 4, so the full trace period from 8'h00 is 16.
- Reset: FSM to IDLE. out_valid, busy, done and fixpoint_hit go to 0. out_cur, out_nxt and step_count go to 0.
- Reset applies from any state, including mid-stream with out_valid high; there is no drain.
- FSM states and transitions:
  - IDLE: wait for start. On start: cur <= INIT_STATE, step_count <= 0, latch max_steps, go to EMIT.
  - EMIT:
    - out_valid = 1. out_cur = cur (registered). out_nxt = f(cur), computed from the registered cur with no extra latency.
    - Handshake is out_valid & out_ready. When it occurs:
      - step_count increments and cur <= out_nxt.
      - If out_nxt == INIT_STATE: fixpoint_hit <= 1, go to DONE.
      - Else if max_steps != 0 and step_count+1 == max_steps: fixpoint_hit <= 0, go to DONE.
      - Else stay in EMIT.
    - When both limit and fixpoint occur on the same beat, fixpoint takes priority and fixpoint_hit = 1.
  - DONE:
    - out_valid = 0, done = 1.
    - out_cur, out_nxt and step_count hold their final values.
    - start restarts exactly as from IDLE and clears done and fixpoint_hit.
- Stream rules:
  - While out_valid=1 and out_ready=0, out_cur and out_nxt stay stable.
  - out_valid never drops without a handshake, except on rst.
  - The first beat is presented on the cycle after start.
  - With out_ready held at 1, one beat is accepted per cycle.
- start is ignored in EMIT.
- step_count wraps modulo 2^CNT_W; with max_steps=0 the fixpoint always terminates the trace within 16 beats.

Decomposition:
- Shared package dpf_pkg holds:
  - state typedef with fields a[2:0], b[2:0], m0, m1;
  - INIT_STATE constant;
  - FSM enum {IDLE, EMIT, DONE}.
- Sub-module dpf_next_state: purely combinational transition function, 8-bit cur in, 8-bit nxt out.
  - The FSM instantiates it.
  - The bench reuses it as its reference model.

Test Plan:
- Free run: rst, start with max_steps=0 and out_ready=1.
  - Beats 1-5 are (00,41), (41,C9), (C9,8A), (8A,12), (12,53).
  - Beat 16 has out_nxt=00.
  - Then done=1, fixpoint_hit=1, step_count=16, out_valid=0.
- Backpressure: out_ready=0 for 3 cycles while beat 2 is presented.
  - out_cur=41 and out_nxt=C9 are held stable across those cycles.
  - No beat is lost or duplicated; the final step_count is 16.
- Limit: start with max_steps=5.
  - Exactly 5 beats are emitted, the last being (12,53).
  - done=1, fixpoint_hit=0, step_count=5.
- Limit equals period: max_steps=16.
  - done after 16 beats with fixpoint_hit=1 (fixpoint takes priority).
- start during EMIT after beat 3: ignored, and the trace continues with (8A,12).
- Reset mid-run: rst asserted after beat 7.
  - Next cycle: out_valid=0, busy=0, done=0, step_count=0.
  - A subsequent start re-emits (00,41) first.
